// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, fixed-latency imem requests, {pc, instr} queue to decode.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [31:0]        r_pc;
    logic [31:0]        r_pend_pc;
    logic               r_pending;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_hold_pc;
    logic [31:0]        r_hold_instr;

    logic               w_resp;
    logic               w_bypass;
    logic               w_pop;
    logic               w_fifo_pop;
    logic               w_push;
    logic               w_issue;
    logic [CNT_W-1:0]   w_occupancy;
    entry_t             w_head;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        w_resp = imem_resp_valid && r_pending && !redirect_valid;
`ifdef FETCH_BYPASS_EN
        w_bypass = w_resp && (r_count == '0);
`else
        w_bypass = 1'b0;
`endif
        w_head      = w_bypass ? {r_pend_pc, imem_resp_data} : r_mem[r_rd_ptr];
        out_valid   = !redirect_valid && ((r_count != '0) || w_bypass);
        w_pop       = out_valid && out_ready;
        w_fifo_pop  = w_pop && !w_bypass;
        w_push      = w_resp && !(w_bypass && out_ready);
        w_occupancy = r_count + CNT_W'(r_pending);
        w_issue     = !redirect_valid && ((w_occupancy < CNT_W'(DEPTH)) || w_pop);
        // A request is never presented while the block is held in reset.
        imem_req_valid = w_issue && reset;
        imem_req_addr  = r_pc;
        out_pc         = out_valid ? w_head.pc    : r_hold_pc;
        out_instr      = out_valid ? w_head.instr : r_hold_instr;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= RESET_PC;
            r_pend_pc    <= '0;
            r_pending    <= 1'b0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_hold_pc    <= '0;
            r_hold_instr <= '0;
        end else if (redirect_valid) begin
            r_pc      <= {redirect_pc[31:2], 2'b00};
            r_pending <= 1'b0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
        end else begin
            if (w_issue) begin
                r_pend_pc <= r_pc;
                r_pc      <= r_pc + 32'd4;
            end
            r_pending <= w_issue;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_fifo_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_fifo_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (out_valid) begin
                r_hold_pc    <= w_head.pc;
                r_hold_instr <= w_head.instr;
            end
        end
    end

    // NOTE: queue storage has no reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_pend_pc, imem_resp_data};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written redirect/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_fetch_unit;

    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct {
        logic        do_rst;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_ov;
        logic [31:0] exp_pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model state: request seen last cycle and its address.
    logic        mem_fire  = 1'b0;
    logic [31:0] mem_addr  = '0;
    bit          mem_const = 1'b1;

    // Reference model state.
    entry_t      m_q[$];
    logic [31:0] m_pc, m_pend_pc, m_last_pc, m_last_instr;
    bit          m_pending;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (mem_const) return 32'h0000_0013;
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One clock cycle: inputs applied just after the rising edge, outputs settled at the falling edge.
    task automatic cycle(input logic rdv, input logic [31:0] rpc, input logic rdy, input logic spur);
        @(posedge clk);
        #1;
        reset           = 1'b1;
        imem_resp_valid = mem_fire | spur;
        imem_resp_data  = mem_word(mem_addr);
        redirect_valid  = rdv;
        redirect_pc     = rpc;
        out_ready       = rdy;
        @(negedge clk);
        mem_fire = imem_req_valid && reset;
        mem_addr = imem_req_addr;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset           = 1'b0;
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        out_ready       = 1'b0;
        mem_fire        = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc         = 32'h0000_0000;
        m_pend_pc    = '0;
        m_last_pc    = '0;
        m_last_instr = '0;
        m_pending    = 1'b0;
    endtask

    // Expected behaviour from the fetch rules: queue of fetched words, one outstanding request.
    task automatic model_step();
        entry_t head;
        bit     resp, byp, ov, pop, issue;
        int     occ;
        resp = imem_resp_valid && m_pending && !redirect_valid;
        byp  = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = resp && (m_q.size() == 0);
`endif
        ov = !redirect_valid && (m_q.size() != 0 || byp);
        if (!ov)                 head = {m_last_pc, m_last_instr};
        else if (byp)            head = {m_pend_pc, imem_resp_data};
        else                     head = m_q[0];
        pop   = ov && out_ready;
        occ   = m_q.size() + int'(m_pending);
        issue = !redirect_valid && (occ < DEPTH || pop);
        check1("rnd_req_valid", imem_req_valid, issue);
        check("rnd_req_addr", imem_req_addr, m_pc);
        check1("rnd_out_valid", out_valid, ov);
        check("rnd_out_pc", out_pc, head.pc);
        check("rnd_out_instr", out_instr, head.instr);
        m_last_pc    = head.pc;
        m_last_instr = head.instr;
        if (redirect_valid) begin
            m_q.delete();
            m_pending = 1'b0;
            m_pc      = redirect_pc & ~32'h3;
        end else begin
            if (pop && !byp) void'(m_q.pop_front());
            if (resp && !(byp && pop)) m_q.push_back({m_pend_pc, imem_resp_data});
            if (issue) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
            m_pending = issue;
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic rdy, input logic req,
                                input logic [31:0] addr, input logic ov, input logic [31:0] pc);
        vec_t v;
        v.do_rst   = rst;
        v.rdy      = rdy;
        v.exp_req  = req;
        v.exp_addr = addr;
        v.exp_ov   = ov;
        v.exp_pc   = pc;
        return v;
    endfunction

    initial begin
        vec_t vecs[21];
        int   found;
        int   nout;
        logic [31:0] exp_pc;

        // Streaming from reset with decode always ready.
        vecs[0]  = mk(1, 1, 1, 32'h00, 0,        32'h0);
        vecs[1]  = mk(0, 1, 1, 32'h04, LAT == 1, 32'h0);
        vecs[2]  = mk(0, 1, 1, 32'h08, 1,        (LAT == 1) ? 32'h4 : 32'h0);
        vecs[3]  = mk(0, 1, 1, 32'h0C, 1,        (LAT == 1) ? 32'h8 : 32'h4);
        vecs[4]  = mk(0, 1, 1, 32'h10, 1,        (LAT == 1) ? 32'hC : 32'h8);
        // Decode stalled for 10 cycles, then drains with fetch resuming at 0x10.
        vecs[5]  = mk(1, 0, 1, 32'h00, 0,        32'h0);
        vecs[6]  = mk(0, 0, 1, 32'h04, LAT == 1, 32'h0);
        vecs[7]  = mk(0, 0, 1, 32'h08, 1,        32'h0);
        vecs[8]  = mk(0, 0, 1, 32'h0C, 1,        32'h0);
        vecs[9]  = mk(0, 0, 0, 32'h10, 1,        32'h0);
        vecs[10] = mk(0, 0, 0, 32'h10, 1,        32'h0);
        vecs[11] = mk(0, 0, 0, 32'h10, 1,        32'h0);
        vecs[12] = mk(0, 0, 0, 32'h10, 1,        32'h0);
        vecs[13] = mk(0, 0, 0, 32'h10, 1,        32'h0);
        vecs[14] = mk(0, 0, 0, 32'h10, 1,        32'h0);
        vecs[15] = mk(0, 1, 1, 32'h10, 1,        32'h0);
        vecs[16] = mk(0, 1, 1, 32'h14, 1,        32'h4);
        vecs[17] = mk(0, 1, 1, 32'h18, 1,        32'h8);
        vecs[18] = mk(0, 1, 1, 32'h1C, 1,        32'hC);
        vecs[19] = mk(0, 1, 1, 32'h20, 1,        32'h10);
        vecs[20] = mk(0, 1, 1, 32'h24, 1,        32'h14);

        mem_const = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (vecs[i].do_rst) do_reset();
            cycle(1'b0, 32'h0, vecs[i].rdy, 1'b0);
            check1($sformatf("vec%0d_req_valid", i), imem_req_valid, vecs[i].exp_req);
            check($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].exp_addr);
            check1($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
            check($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_out_instr", i), out_instr,
                  vecs[i].exp_ov ? 32'h13 : 32'h0);
        end

        // Redirect with 3 queued and 1 in flight: stale response dropped, restart at 0x100.
        mem_const = 1'b0;
        do_reset();
        repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h103, 1'b0, 1'b0);
        check1("redir_out_valid", out_valid, 1'b0);
        check1("redir_req_valid", imem_req_valid, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check1("redir_next_req", imem_req_valid, 1'b1);
        check("redir_next_addr", imem_req_addr, 32'h100);
        check1("redir_flushed", out_valid, 1'b0);
        found = -1;
        for (int k = 2; k <= 6; k++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
            if (out_valid && found >= 0 && found == k - 1) begin
                check("redir_second_pc", out_pc, 32'h104);
            end
            if (out_valid && found < 0) begin
                found = k;
                check("redir_first_pc", out_pc, 32'h100);
                check("redir_first_instr", out_instr, mem_word(32'h100));
            end
        end
        check("redir_latency", 32'(found), 32'(LAT + 1));

        // Two consecutive redirects: only the 0x300 stream may ever appear.
        do_reset();
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h200, 1'b0, 1'b0);
        cycle(1'b1, 32'h300, 1'b0, 1'b0);
        check1("dbl_req_valid", imem_req_valid, 1'b0);
        check("dbl_mid_addr", imem_req_addr, 32'h200);
        check1("dbl_out_valid", out_valid, 1'b0);
        exp_pc = 32'h300;
        nout   = 0;
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
            if (out_valid) begin
                check($sformatf("dbl_pc%0d", nout), out_pc, exp_pc);
                check($sformatf("dbl_instr%0d", nout), out_instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                nout++;
            end
        end
        check("dbl_count", 32'(nout), 32'(12 - LAT));

        // Asynchronous reset mid-stream, then restart from RESET_PC.
        mem_const = 1'b1;
        do_reset();
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        reset           = 1'b0;
        imem_resp_valid = 1'b0;
        mem_fire        = 1'b0;
        #1;
        check1("arst_req_valid", imem_req_valid, 1'b0);
        check("arst_req_addr", imem_req_addr, 32'h0);
        check1("arst_out_valid", out_valid, 1'b0);
        check("arst_out_pc", out_pc, 32'h0);
        check("arst_out_instr", out_instr, 32'h0);
        repeat (2) @(posedge clk);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check1("arst_first_req", imem_req_valid, 1'b1);
        check("arst_first_addr", imem_req_addr, 32'h0);
        repeat (LAT) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check1("arst_first_valid", out_valid, 1'b1);
        check("arst_first_pc", out_pc, 32'h0);

        // Randomized traffic against the reference model.
        mem_const = 1'b0;
        do_reset();
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            logic rdy, rdv, spur;
            logic [31:0] rpc;
            rdy  = $urandom_range(0, 99) < (((i / 200) % 2 == 1) ? 30 : 85);
            rdv  = $urandom_range(0, 99) < 4;
            rpc  = $urandom;
            spur = !mem_fire && ($urandom_range(0, 9) == 0);
            cycle(rdv, rpc, rdy, spur);
            model_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
